// File: rtl/score_display_ctrl.sv
// Score display: binary score -> 6 BCD digits via a serial double-dabble
// engine, latched into a display register and decoded to active-low segments.

module score_digit_dec (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end
endmodule

module score_display_ctrl #(
  parameter int WIDTH     = 20,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  input  logic             blank_lz,
  input  logic             blink_en,
  output logic             busy,
  output logic             done,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5
);
  localparam int          NDIG = 6;
  localparam int          CNTW = $clog2(WIDTH + 1);
  localparam int          BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [31:0] MAXV = 32'd999999;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t                     state;
  logic [WIDTH-1:0]           bin;
  logic [NDIG-1:0][3:0]       bcd, bcd_adj, disp;
  logic [CNTW-1:0]            cnt;
  logic [BW-1:0]              bcnt;
  logic                       phase;
  logic [NDIG-1:0]            lz;
  logic [NDIG-1:0][6:0]       segs;
  logic                       blink_on;

  always_comb begin
    for (int i = 0; i < NDIG; i++)
      bcd_adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
      bcd   <= '0;
      disp  <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          // Clamp so the six digits can always represent the score
          if ({{(32-WIDTH){1'b0}}, value} > MAXV) bin <= MAXV[WIDTH-1:0];
          else                                    bin <= value;
          bcd   <= '0;
          cnt   <= CNTW'(WIDTH);
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt - 1'b1;
          if (cnt == CNTW'(1)) state <= LATCH;
        end
        LATCH: begin
          disp  <= bcd;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // A digit blanks only when it and every digit above it are zero
  always_comb begin
    logic zrun;
    zrun = 1'b1;
    lz   = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zrun  = zrun & (disp[i] == 4'd0);
      lz[i] = blank_lz & zrun;
    end
  end

  assign blink_on = blink_en & phase;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    score_digit_dec u_dec (
      .digit (disp[g]),
      .blank (blink_on | lz[g]),
      .seg   (segs[g])
    );
  end

  assign hex0 = segs[0];
  assign hex1 = segs[1];
  assign hex2 = segs[2];
  assign hex3 = segs[3];
  assign hex4 = segs[4];
  assign hex5 = segs[5];
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: vector table of loads plus
// hand sequences for busy-load, blink, blanking toggle and reset abort.

module tb_score_display_ctrl;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         reset, load, blank_lz, blink_en;
  logic [W-1:0] value;
  logic         busy, done;
  logic [6:0]   hex0, hex1, hex2, hex3, hex4, hex5;

  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;
  logic mph    = 1'b0;

  score_display_ctrl #(.WIDTH(W), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .done(done),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    v;
    logic            lz;
    logic [5:0][6:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [41:0] hexall();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock; also steps the blink-phase model using the reset seen at the edge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      mcnt = 0; mph = 1'b0;
    end else if (mcnt == 3) begin
      mcnt = 0; mph = ~mph;
    end else begin
      mcnt++;
    end
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v, output int lat);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    value = W'($urandom);
    chk("busy_after_load", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, ndone;
    logic [41:0] pat;

    vecs[0] = '{20'd123456,  1'b0, {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02}};
    vecs[1] = '{20'd1048575, 1'b0, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}};
    vecs[2] = '{20'd507,     1'b1, {7'h7F,7'h7F,7'h7F,7'h12,7'h40,7'h78}};
    vecs[3] = '{20'd0,       1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}};
    vecs[4] = '{20'd999999,  1'b0, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}};
    vecs[5] = '{20'd1000000, 1'b0, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}};
    vecs[6] = '{20'd100000,  1'b1, {7'h79,7'h40,7'h40,7'h40,7'h40,7'h40}};
    vecs[7] = '{20'd9,       1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h10}};
    vecs[8] = '{20'd80,      1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h00,7'h40}};

    reset = 1'b1; load = 1'b0; blank_lz = 1'b0; blink_en = 1'b0; value = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hex",  {22'd0, hexall()}, {22'd0, {6{7'h40}}});

    foreach (vecs[i]) begin
      blank_lz = vecs[i].lz;
      do_load(vecs[i].v, lat);
      chk($sformatf("latency_%0d", i), 64'(lat), 64'd21);
      chk($sformatf("hex_%0d", i), {22'd0, hexall()}, {22'd0, vecs[i].exp});
      tick();
      chk($sformatf("done_pulse_%0d", i), {63'd0, done}, 64'd0);
      chk($sformatf("idle_busy_%0d", i), {63'd0, busy}, 64'd0);
    end

    // blank_lz toggles take effect without a clock
    blank_lz = 1'b1;
    do_load(20'd507, lat);
    chk("lz_on", {22'd0, hexall()}, {22'd0, {7'h7F,7'h7F,7'h7F,7'h12,7'h40,7'h78}});
    blank_lz = 1'b0;
    #1;
    chk("lz_off", {22'd0, hexall()}, {22'd0, {7'h40,7'h40,7'h40,7'h12,7'h40,7'h78}});

    // Loads while busy are ignored
    tick();
    value = 20'd321; load = 1'b1; tick(); load = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3 || c == 15) begin value = 20'd999999; load = 1'b1; end
      tick();
      load = 1'b0;
      if (done) ndone++;
    end
    chk("busy_load_ndone", 64'(ndone), 64'd1);
    chk("busy_load_hex", {22'd0, hexall()}, {22'd0, {7'h40,7'h40,7'h40,7'h30,7'h24,7'h79}});

    // Blink: phase flips every 4 cycles
    do_load(20'd123456, lat);
    pat = {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02};
    blink_en = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("blink_%0d", c), {22'd0, hexall()},
          {22'd0, mph ? {6{7'h7F}} : pat});
      tick();
    end
    blink_en = 1'b0;
    #1;
    chk("blink_off", {22'd0, hexall()}, {22'd0, pat});

    // Reset mid-conversion aborts and clears the display
    value = 20'd654321; load = 1'b1; tick(); load = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1; load = 1'b1; tick(); reset = 1'b0; load = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hex",  {22'd0, hexall()}, {22'd0, {6{7'h40}}});
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_quiet", 64'(ndone), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Drives the six on-board seven-segment digits (HEX0..HEX5) with the current game score.
- Accepts a binary score through a load/busy handshake and converts it to six BCD digits with a sequential shift-add-3 (double-dabble) engine, one shift per clock.
- Latches the digits into a display register and decodes each digit to active-low segments.
- Supports optional leading-zero blanking, and whole-display blinking for the game-over indication.

Parameters:
- WIDTH, 20, bit width of the input score; legal range 1..20.
- BLINK_DIV, 25000000, clock cycles per blink half-period.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- value  input  WIDTH  binary score; sampled only on an accepted load.
- load  input  1  conversion request; accepted only in IDLE.
- blank_lz  input  1  1 = blank leading zero digits (HEX5 down to HEX1).
- blink_en  input  1  1 = blink the whole display.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the display register is updated.
- hex0..hex5  output  7 each  active-low segments; bit0 = a ... bit6 = g; hex0 is the least-significant digit.

Behaviour:
- One clock. Reset is synchronous and active-high; the ports are clk and reset.
- Reset state:
  - FSM = IDLE; busy = 0; done = 0.
  - Display register = 000000; shift register = 0.
  - Blink counter = 0; blink phase = 0.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - On load=1, capture value into the shift register. If value > 999999, capture 999999 instead (saturate).
  - Clear the BCD accumulator, set the shift count to WIDTH, and go to SHIFT.
  - load=0 keeps the FSM in IDLE.
- SHIFT (one step per cycle):
  - Add 3 to every BCD digit that is >= 5.
  - Then shift {bcd, bin} left by 1 and decrement the count.
  - When the count reaches 0 after a shift, go to LATCH.
- LATCH:
  - Copy the BCD accumulator to the display register.
  - Assert done for exactly this one cycle, then return to IDLE.
- busy = 1 in SHIFT and LATCH, 0 in IDLE.
- Latency: load sampled at edge k; display register and done are visible after edge k+WIDTH+1. This is 21 cycles at WIDTH=20.
- The next load can be accepted at edge k+WIDTH+2.
- load while busy is ignored: no queueing, no restart.
- value is don't-care outside the accepting cycle.
- The display register holds the old score during a conversion, so there is no visible tearing.
- Segment decode per digit (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19.
  - 5=12, 6=02, 7=78, 8=00, 9=10.
  - blank = 7F.
- Leading-zero blanking:
  - For i = 5..1, digit i is blanked if blank_lz=1 and digits i..5 are all zero.
  - hex0 is never blanked by this rule.
- Blink:
  - The counter free-runs 0..BLINK_DIV-1; on wrap it toggles the phase.
  - When blink_en=1 and phase=1, all hex outputs = 7F.
  - The counter runs regardless of blink_en.
- hex outputs are combinational from the display register, blank_lz, blink_en and the phase. blank_lz and blink_en take effect in the same cycle.
- Reset mid-conversion aborts the conversion: the FSM returns to IDLE, no done pulse occurs, and the display register is cleared to 0.
- Reset and load in the same cycle: reset wins and the load is lost.

Test Plan:
- Reset, blank_lz=0, blink_en=0 -> busy=0, done=0; hex5..hex0 all = 40.
- Load value=123456 at edge k -> busy=1 from k+1; done=1 only after edge k+21. Then hex5..hex0 = 79,24,30,19,12,02.
- Load value=1048575 (over range) -> display 999999; all six hex = 10.
- Load value=507, blank_lz=1 -> hex5..hex3 = 7F, hex2=12, hex1=40, hex0=78. Set blank_lz=0 -> hex5..hex3 = 40 in the same cycle.
- Load value=0, blank_lz=1 -> hex5..hex1 = 7F, hex0=40.
- Second load pulsed while busy -> ignored: exactly one done pulse, and the display shows the first value.
- BLINK_DIV=4, blink_en=1 -> all hex alternate between the digit patterns and 7F every 4 cycles.
- Reset asserted mid-SHIFT -> next cycle busy=0; no done pulse; display = 000000.
